// File: rtl/mem_adapter_dp.sv
// mem_adapter_dp: two independent channels (A = fetch, B = load/store) over one
// shared dual-port RAM. Each channel has its own read latency and a one-cycle
// dready pulse. Same-address writes merge by byte, with B winning on overlap.
// Reads in the same cycle as a write return the old data.
// Optional feature: define MEMADP_COLLISION_FLAG_EN to add a sticky coll_flag output.

// Per-channel control: IDLE -> (WAIT) -> DONE -> IDLE, with registered dout/dready.
module mem_adapter_dp_chan #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              re_i,
   input  logic              wr_req_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic              wr_acc_c_o,
   output logic              rd_acc_c_o,
   output logic [DATA_W-1:0] dout_o,
   output logic              dready_o
);
   localparam int unsigned CNT_W = $clog2(LAT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] dout_q;
   logic              dready_q;

   // A request is only accepted in IDLE; a write wins over a read.
   assign wr_acc_c_o = (state_q == IDLE) && wr_req_i;
   assign rd_acc_c_o = (state_q == IDLE) && !wr_req_i && re_i;

   // Channel state machine; dready is registered together with the move into DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dout_q   <= '0;
         dready_q <= 1'b0;
      end else begin
         dready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (wr_req_i) begin
                  state_q  <= DONE;
                  dready_q <= 1'b1;
               end else if (re_i) begin
                  dout_q <= rdata_i;
                  if (LAT == 1) begin
                     state_q  <= DONE;
                     dready_q <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_W'(LAT - 1);
                  end
               end
            end
            WAIT: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (!re_i) begin
                  state_q <= IDLE;
               end else if (cnt_q == CNT_W'(1)) begin
                  state_q  <= DONE;
                  dready_q <= 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dout_o   = dout_q;
   assign dready_o = dready_q;
endmodule

module mem_adapter_dp #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LAT_A  = 1,
   parameter int unsigned LAT_B  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rea,
   input  logic [DATA_W/8-1:0] wea,
   input  logic [ADDR_W-1:0]   addra,
   input  logic [DATA_W-1:0]   dina,
   output logic [DATA_W-1:0]   douta,
   output logic                dreadya,
   input  logic                reb,
   input  logic [DATA_W/8-1:0] web,
   input  logic [ADDR_W-1:0]   addrb,
   input  logic [DATA_W-1:0]   dinb,
   output logic [DATA_W-1:0]   doutb,
   output logic                dreadyb
`ifdef MEMADP_COLLISION_FLAG_EN
   ,
   output logic                coll_flag
`endif
);
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_a, rdata_b;
   logic              wr_a, rd_a, wr_b, rd_b;
   logic [NB-1:0]     lane_a, lane_b;
   logic              same_addr;

   assign rdata_a   = mem_q[addra];
   assign rdata_b   = mem_q[addrb];
   assign same_addr = (addra == addrb);

   mem_adapter_dp_chan #(.DATA_W(DATA_W), .LAT(LAT_A)) u_chan_a (
      .clk        (clk),
      .rst        (rst),
      .re_i       (rea),
      .wr_req_i   (|wea),
      .rdata_i    (rdata_a),
      .wr_acc_c_o (wr_a),
      .rd_acc_c_o (rd_a),
      .dout_o     (douta),
      .dready_o   (dreadya)
   );

   mem_adapter_dp_chan #(.DATA_W(DATA_W), .LAT(LAT_B)) u_chan_b (
      .clk        (clk),
      .rst        (rst),
      .re_i       (reb),
      .wr_req_i   (|web),
      .rdata_i    (rdata_b),
      .wr_acc_c_o (wr_b),
      .rd_acc_c_o (rd_b),
      .dout_o     (doutb),
      .dready_o   (dreadyb)
   );

   // Byte-lane write enables; B takes any lane both ports write at the same address.
   always_comb begin
      lane_a = '0;
      lane_b = '0;
      for (int i = 0; i < int'(NB); i++) begin
         lane_b[i] = wr_b && web[i];
         lane_a[i] = wr_a && wea[i] && !(lane_b[i] && same_addr);
      end
   end

   // Shared RAM array; contents survive reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NB); i++) begin
         if (lane_a[i]) mem_q[addra][i*8 +: 8] <= dina[i*8 +: 8];
         if (lane_b[i]) mem_q[addrb][i*8 +: 8] <= dinb[i*8 +: 8];
      end
   end

`ifdef MEMADP_COLLISION_FLAG_EN
   logic coll_q;

   // Sticky flag: both ports hit one address in one cycle with at least one write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coll_q <= 1'b0;
      end else if (same_addr && (wr_a || rd_a) && (wr_b || rd_b) && (wr_a || wr_b)) begin
         coll_q <= 1'b1;
      end
   end

   assign coll_flag = coll_q;
`endif
endmodule

// File: tb/tb_mem_adapter_dp.sv
// Bench for mem_adapter_dp: transaction-level model (per-channel completion time,
// snapshot data, byte-merged memory image) compared every cycle, plus literal checks.
module tb_mem_adapter_dp;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;
   localparam int LAT_A  = 1;
   localparam int LAT_B  = 2;
   localparam int NB     = DATA_W / 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              rea, reb;
   logic [NB-1:0]     wea, web;
   logic [ADDR_W-1:0] addra, addrb;
   logic [DATA_W-1:0] dina, dinb, douta, doutb;
   logic              dreadya, dreadyb;
`ifdef MEMADP_COLLISION_FLAG_EN
   logic              coll_flag;
`endif

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   mem_adapter_dp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT_A(LAT_A), .LAT_B(LAT_B)) dut (
      .clk     (clk),
      .rst     (rst),
      .rea     (rea),
      .wea     (wea),
      .addra   (addra),
      .dina    (dina),
      .douta   (douta),
      .dreadya (dreadya),
      .reb     (reb),
      .web     (web),
      .addrb   (addrb),
      .dinb    (dinb),
      .doutb   (doutb),
      .dreadyb (dreadyb)
`ifdef MEMADP_COLLISION_FLAG_EN
      ,
      .coll_flag (coll_flag)
`endif
   );

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DATA_W-1:0] m_mem [DEPTH];
   int                cyc = 0;
   int                m_due [2];   // edge count after which dready is high
   int                m_acc [2];   // edge count of the accepting edge
   bit                m_rd  [2];
   bit                m_rdy [2];
   logic [DATA_W-1:0] m_dout [2];
   bit                m_coll;

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_due[c]  = -10;
         m_acc[c]  = -10;
         m_rd[c]   = 1'b0;
         m_rdy[c]  = 1'b0;
         m_dout[c] = '0;
      end
      m_coll = 1'b0;
   endtask

   task automatic model_step();
      logic              re_v [2];
      logic [NB-1:0]     we_v [2];
      logic [ADDR_W-1:0] ad_v [2];
      logic [DATA_W-1:0] dn_v [2];
      bit                aw [2];
      bit                ar [2];
      int                lat_v [2];
      if (!rst) return;
      cyc++;
      re_v[0] = rea; we_v[0] = wea; ad_v[0] = addra; dn_v[0] = dina; lat_v[0] = LAT_A;
      re_v[1] = reb; we_v[1] = web; ad_v[1] = addrb; dn_v[1] = dinb; lat_v[1] = LAT_B;
      for (int c = 0; c < 2; c++) begin
         // a channel is free again two edges after its completion edge
         aw[c] = (cyc >= m_due[c] + 2) && (we_v[c] != '0);
         ar[c] = (cyc >= m_due[c] + 2) && (we_v[c] == '0) && re_v[c];
      end
      if (ad_v[0] == ad_v[1] && (aw[0] || ar[0]) && (aw[1] || ar[1]) && (aw[0] || aw[1]))
         m_coll = 1'b1;
      for (int c = 0; c < 2; c++) begin
         if (ar[c]) begin
            m_dout[c] = m_mem[ad_v[c]];
            m_acc[c]  = cyc;
            m_due[c]  = cyc + lat_v[c] - 1;
            m_rd[c]   = 1'b1;
         end else if (aw[c]) begin
            m_acc[c] = cyc;
            m_due[c] = cyc;
            m_rd[c]  = 1'b0;
         end else if (m_rd[c] && cyc > m_acc[c] && cyc <= m_due[c] && !re_v[c]) begin
            m_due[c] = cyc - 1;   // aborted read: no pulse, free next edge
         end
      end
      for (int c = 0; c < 2; c++)
         if (aw[c])
            for (int i = 0; i < NB; i++)
               if (we_v[c][i]) m_mem[ad_v[c]][i*8 +: 8] = dn_v[c][i*8 +: 8];
      for (int c = 0; c < 2; c++) m_rdy[c] = (cyc == m_due[c]);
   endtask

   always @(posedge clk) model_step();
   always @(negedge rst) model_reset();

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst && cmp_en) begin
         chk("dreadya", DATA_W'(dreadya), DATA_W'(m_rdy[0]));
         chk("dreadyb", DATA_W'(dreadyb), DATA_W'(m_rdy[1]));
         chk("douta", douta, m_dout[0]);
         chk("doutb", doutb, m_dout[1]);
`ifdef MEMADP_COLLISION_FLAG_EN
         chk("coll_flag", DATA_W'(coll_flag), DATA_W'(m_coll));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle_inputs();
      rea = 1'b0; reb = 1'b0; wea = '0; web = '0;
      addra = '0; addrb = '0; dina = '0; dinb = '0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input int ch, input logic [ADDR_W-1:0] a, input logic [NB-1:0] m,
                     input logic [DATA_W-1:0] d);
      if (ch == 0) begin wea = m; addra = a; dina = d; end
      else         begin web = m; addrb = a; dinb = d; end
      step(1);
      wea = '0; web = '0;
      chk("wr_dready", DATA_W'((ch == 0) ? dreadya : dreadyb), DATA_W'(1));
      step(1);
   endtask

   task automatic rd(input int ch, input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] q,
                     output int lat);
      if (ch == 0) begin rea = 1'b1; addra = a; end
      else         begin reb = 1'b1; addrb = a; end
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         step(1);
         if ((ch == 0) ? dreadya : dreadyb) begin
            lat = k;
            break;
         end
      end
      q = (ch == 0) ? douta : doutb;
      if (ch == 0) rea = 1'b0; else reb = 1'b0;
      step(1);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic [DATA_W-1:0] q, qa, qb;
      int                lat, la, lb;
      model_reset();
      idle_inputs();
      rst = 1'b0;
      #2;
      chk("rst_dreadya", DATA_W'(dreadya), DATA_W'(0));
      chk("rst_dreadyb", DATA_W'(dreadyb), DATA_W'(0));
      chk("rst_douta", douta, '0);
      chk("rst_doutb", doutb, '0);
      #10 rst = 1'b1;
      step(1);
      cmp_en = 1'b1;

      // fill the array: A even words, B odd words, concurrently
      for (int a = 0; a < DEPTH; a += 2) begin
         wea = '1; addra = ADDR_W'(a);     dina = $urandom;
         web = '1; addrb = ADDR_W'(a + 1); dinb = $urandom;
         step(1);
         wea = '0; web = '0;
         step(1);
      end

      // write then read on B
      wr(1, 7'd5, 4'hF, 32'hDEADBEEF);
      rd(1, 7'd5, q, lat);
      chk("t2_lat", DATA_W'(lat), DATA_W'(2));
      chk("t2_data", q, 32'hDEADBEEF);

      // byte enables on A
      wr(0, 7'd3, 4'hF, 32'h11223344);
      wr(0, 7'd3, 4'b0101, 32'hAABBCCDD);
      rd(0, 7'd3, q, lat);
      chk("t3_lat", DATA_W'(lat), DATA_W'(1));
      chk("t3_data", q, 32'h11BB33DD);

      // abort on B: dout keeps the value, no pulse, next read fine
      wr(1, 7'd7, 4'hF, 32'h0BADF00D);
      rd(1, 7'd7, q, lat);
      reb = 1'b1; addrb = 7'd7;
      step(1);
      chk("t4_nordy1", DATA_W'(dreadyb), DATA_W'(0));
      reb = 1'b0;
      step(1);
      chk("t4_nordy2", DATA_W'(dreadyb), DATA_W'(0));
      chk("t4_dout", doutb, 32'h0BADF00D);
      rd(1, 7'd5, q, lat);
      chk("t4_lat", DATA_W'(lat), DATA_W'(2));
      chk("t4_data", q, 32'hDEADBEEF);

`ifdef MEMADP_COLLISION_FLAG_EN
      chk("t5_flag_pre", DATA_W'(coll_flag), DATA_W'(0));
`endif
      // same-address double write
      wea = 4'hF; addra = 7'd9; dina = 32'h0;
      web = 4'h3; addrb = 7'd9; dinb = 32'hFFFF;
      step(1);
      wea = '0; web = '0;
      chk("t5_rdya", DATA_W'(dreadya), DATA_W'(1));
      chk("t5_rdyb", DATA_W'(dreadyb), DATA_W'(1));
      step(1);
      rd(0, 7'd9, q, lat);
      chk("t5_data", q, 32'h0000FFFF);
`ifdef MEMADP_COLLISION_FLAG_EN
      chk("t5_flag", DATA_W'(coll_flag), DATA_W'(1));
`endif

      // concurrent reads with different latencies
      wr(0, 7'd1, 4'hF, 32'hA1A1A1A1);
      wr(1, 7'd2, 4'hF, 32'hB2B2B2B2);
      rea = 1'b1; addra = 7'd1; reb = 1'b1; addrb = 7'd2;
      la = 0; lb = 0; qa = '0; qb = '0;
      for (int k = 1; k <= 10; k++) begin
         step(1);
         if (dreadya && la == 0) begin la = k; qa = douta; rea = 1'b0; end
         if (dreadyb && lb == 0) begin lb = k; qb = doutb; reb = 1'b0; end
         if (la != 0 && lb != 0) break;
      end
      rea = 1'b0; reb = 1'b0;
      chk("t6_lata", DATA_W'(la), DATA_W'(1));
      chk("t6_latb", DATA_W'(lb), DATA_W'(2));
      chk("t6_da", qa, 32'hA1A1A1A1);
      chk("t6_db", qb, 32'hB2B2B2B2);
      step(1);

      // asynchronous reset in the middle of a B wait
      reb = 1'b1; addrb = 7'd5;
      step(1);
      #2 rst = 1'b0;
      #1;
      chk("t1_dreadyb", DATA_W'(dreadyb), DATA_W'(0));
      chk("t1_doutb", doutb, '0);
      chk("t1_douta", douta, '0);
      idle_inputs();
      #1 rst = 1'b1;
      step(1);
      rd(1, 7'd5, q, lat);
      chk("t1_lat", DATA_W'(lat), DATA_W'(2));
      chk("t1_data", q, 32'hDEADBEEF);

      // randomized traffic, small address window to provoke collisions
      for (int n = 0; n < 4000; n++) begin
         rea   = ($urandom_range(0, 9) < 7);
         reb   = ($urandom_range(0, 9) < 7);
         wea   = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
         web   = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
         addra = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
         addrb = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
         dina  = $urandom;
         dinb  = $urandom;
         step(1);
      end
      idle_inputs();
      step(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
